// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port (core A / loader B) arbiter onto a single-port memory
//
// Optional feature: define MEM_ARBITER_RR_EN for round-robin arbitration of
// simultaneous requests; without it port A has fixed priority.
//
// Ports:
//   clk, rst                  clock, synchronous active-low reset
//   req_x, we_x, addr_x,      request side for port A (core) and B (loader);
//   wdata_x                   requester holds these until ack_x
//   ack_x, rdata_x            one-cycle completion pulse, registered read data
//   mem_addr, mem_rd, mem_wr, memory side; strobes last one cycle, read data
//   mem_wdata, mem_rdata      returns the cycle after mem_rd
//   busy                      high whenever a transaction is in flight
module mem_arbiter #(
  parameter int AWIDTH = 5,
  parameter int DWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_a,
  input  logic              req_b,
  input  logic              we_a,
  input  logic              we_b,
  input  logic [AWIDTH-1:0] addr_a,
  input  logic [AWIDTH-1:0] addr_b,
  input  logic [DWIDTH-1:0] wdata_a,
  input  logic [DWIDTH-1:0] wdata_b,
  output logic              ack_a,
  output logic              ack_b,
  output logic [DWIDTH-1:0] rdata_a,
  output logic [DWIDTH-1:0] rdata_b,
  output logic [AWIDTH-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [DWIDTH-1:0] mem_wdata,
  input  logic [DWIDTH-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

  state_t            state, state_nxt;
  logic [AWIDTH-1:0] lat_addr;
  logic              lat_we;
  logic [DWIDTH-1:0] lat_wdata;
  logic              grant;     // 0 = port A, 1 = port B
  logic              win_b;

`ifdef MEM_ARBITER_RR_EN
  logic last_grant;             // 0 = A served last, 1 = B served last

  // On a tie the port that was not served last wins.
  assign win_b = req_b && (!req_a || !last_grant);

  always_ff @(posedge clk) begin
    if (!rst) begin
      last_grant <= 1'b1;
    end else if (state == IDLE && (req_a || req_b)) begin
      last_grant <= win_b;
    end
  end
`else
  assign win_b = req_b && !req_a;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_wdata = '0;
    ack_a     = 1'b0;
    ack_b     = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE: begin
        if (req_a || req_b) state_nxt = ACCESS;
      end
      ACCESS: begin
        state_nxt = WAIT;
        mem_rd    = !lat_we;
        mem_wr    = lat_we;
        if (lat_we) mem_wdata = lat_wdata;
      end
      WAIT: begin
        state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
        ack_a     = !grant;
        ack_b     = grant;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The latched address doubles as mem_addr; it only changes on a grant,
  // so it is stable through ACCESS, WAIT and DONE.
  assign mem_addr = lat_addr;

  always_ff @(posedge clk) begin
    if (!rst) begin
      lat_addr  <= '0;
      lat_we    <= 1'b0;
      lat_wdata <= '0;
      grant     <= 1'b0;
      rdata_a   <= '0;
      rdata_b   <= '0;
    end else begin
      if (state == IDLE && (req_a || req_b)) begin
        grant     <= win_b;
        lat_addr  <= win_b ? addr_b  : addr_a;
        lat_we    <= win_b ? we_b    : we_a;
        lat_wdata <= win_b ? wdata_b : wdata_a;
      end
      if (state == WAIT && !lat_we) begin
        if (grant) rdata_b <= mem_rdata;
        else       rdata_a <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;

  localparam int AW = 5;
  localparam int DW = 8;

  logic          clk, rst;
  logic          req_a, req_b, we_a, we_b;
  logic [AW-1:0] addr_a, addr_b;
  logic [DW-1:0] wdata_a, wdata_b;
  logic          ack_a, ack_b;
  logic [DW-1:0] rdata_a, rdata_b;
  logic [AW-1:0] mem_addr;
  logic          mem_rd, mem_wr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          busy;

  int errors = 0;
  int checks = 0;

  typedef struct {
    bit            port;   // 0 = A, 1 = B
    logic [DW-1:0] ra;
    logic [DW-1:0] rb;
  } sb_t;

  sb_t           sbq[$];
  logic [DW-1:0] mem     [32];
  logic [DW-1:0] ref_mem [32];
  logic [DW-1:0] exp_ra, exp_rb;

  mem_arbiter #(.AWIDTH(AW), .DWIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .req_b(req_b), .we_a(we_a), .we_b(we_b),
    .addr_a(addr_a), .addr_b(addr_b), .wdata_a(wdata_a), .wdata_b(wdata_b),
    .ack_a(ack_a), .ack_b(ack_b), .rdata_a(rdata_a), .rdata_b(rdata_b),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: synchronous write, read data one cycle after mem_rd.
  always @(posedge clk) begin
    if (mem_wr) mem[mem_addr] <= mem_wdata;
    if (mem_rd) mem_rdata <= mem[mem_addr];
  end

  // Scoreboard: every ack pops the oldest expected completion.
  always @(negedge clk) begin
    if (ack_a || ack_b) begin
      sb_t e;
      checks++;
      if (ack_a && ack_b) begin
        errors++;
        $display("FAIL ack_overlap: ack_a=%b ack_b=%b required one-hot", ack_a, ack_b);
      end
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_ack: ack_a=%b ack_b=%b with nothing expected", ack_a, ack_b);
      end else begin
        e = sbq.pop_front();
        if (ack_b !== e.port) begin
          errors++;
          $display("FAIL sb_port: got port %0d required %0d", ack_b, e.port);
        end
        checks++;
        if (rdata_a !== e.ra) begin
          errors++;
          $display("FAIL sb_rdata_a: got %h required %h", rdata_a, e.ra);
        end
        checks++;
        if (rdata_b !== e.rb) begin
          errors++;
          $display("FAIL sb_rdata_b: got %h required %h", rdata_b, e.rb);
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic expect_read(input bit port, input logic [AW-1:0] a);
    if (port) exp_rb = ref_mem[a];
    else      exp_ra = ref_mem[a];
    sbq.push_back('{port, exp_ra, exp_rb});
  endtask

  task automatic test_reset();
    rst = 1'b0; req_a = 1'b1; addr_a = 5'h03; we_a = 1'b0;
    step();
    checks++;
    if ({busy, ack_a, ack_b, mem_rd, mem_wr} !== 5'b0 || mem_addr !== '0 ||
        mem_wdata !== '0 || rdata_a !== '0 || rdata_b !== '0) begin
      errors++;
      $display("FAIL reset_values: busy=%b ack=%b%b rd=%b wr=%b addr=%h wd=%h ra=%h rb=%h required all 0",
               busy, ack_a, ack_b, mem_rd, mem_wr, mem_addr, mem_wdata, rdata_a, rdata_b);
    end
    step();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold_busy: got %b required 0", busy);
    end
    req_a = 1'b0; rst = 1'b1;
    step();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_req_busy: got %b required 0", busy);
    end
    exp_ra = '0; exp_rb = '0;
  endtask

  task automatic test_read_a();
    req_a = 1'b1; we_a = 1'b0; addr_a = 5'h03;
    expect_read(1'b0, 5'h03);
    step();  // ACCESS
    checks++;
    if (mem_rd !== 1'b1 || mem_wr !== 1'b0 || mem_addr !== 5'h03 || mem_wdata !== '0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL read_access: rd=%b wr=%b addr=%h wd=%h busy=%b required 1 0 03 00 1",
               mem_rd, mem_wr, mem_addr, mem_wdata, busy);
    end
    step();  // WAIT
    checks++;
    if (mem_rd !== 1'b0 || mem_addr !== 5'h03 || ack_a !== 1'b0) begin
      errors++;
      $display("FAIL read_wait: rd=%b addr=%h ack_a=%b required 0 03 0", mem_rd, mem_addr, ack_a);
    end
    step();  // DONE
    checks++;
    if (ack_a !== 1'b1 || ack_b !== 1'b0 || rdata_a !== 8'hA5) begin
      errors++;
      $display("FAIL read_done: ack_a=%b ack_b=%b rdata_a=%h required 1 0 a5", ack_a, ack_b, rdata_a);
    end
    req_a = 1'b0;
    step();  // IDLE
    checks++;
    if (ack_a !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL read_idle: ack_a=%b busy=%b required 0 0", ack_a, busy);
    end
  endtask

  task automatic test_write_b();
    req_b = 1'b1; we_b = 1'b1; addr_b = 5'h1F; wdata_b = 8'h3C;
    sbq.push_back('{1'b1, exp_ra, exp_rb});
    ref_mem[31] = 8'h3C;
    step();  // ACCESS
    checks++;
    if (mem_wr !== 1'b1 || mem_rd !== 1'b0 || mem_addr !== 5'h1F || mem_wdata !== 8'h3C) begin
      errors++;
      $display("FAIL write_access: wr=%b rd=%b addr=%h wd=%h required 1 0 1f 3c",
               mem_wr, mem_rd, mem_addr, mem_wdata);
    end
    step();  // WAIT
    checks++;
    if (mem_wr !== 1'b0 || mem_wdata !== '0 || mem_addr !== 5'h1F) begin
      errors++;
      $display("FAIL write_wait: wr=%b wd=%h addr=%h required 0 00 1f", mem_wr, mem_wdata, mem_addr);
    end
    step();  // DONE
    checks++;
    if (ack_b !== 1'b1 || ack_a !== 1'b0) begin
      errors++;
      $display("FAIL write_done: ack_b=%b ack_a=%b required 1 0", ack_b, ack_a);
    end
    req_b = 1'b0; we_b = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    bit exp_port;
    req_a = 1'b1; we_a = 1'b0; addr_a = 5'h04;
    req_b = 1'b1; we_b = 1'b0; addr_b = 5'h1F;
    for (int t = 0; t < 4; t++) begin
`ifdef MEM_ARBITER_RR_EN
      exp_port = t[0];
`else
      exp_port = 1'b0;
`endif
      expect_read(exp_port, exp_port ? 5'h1F : 5'h04);
      step(); step(); step();  // ACCESS, WAIT, DONE
      checks++;
      if (ack_a !== !exp_port || ack_b !== exp_port) begin
        errors++;
        $display("FAIL grant_order[%0d]: ack_a=%b ack_b=%b required port %0d", t, ack_a, ack_b, exp_port);
      end
      step();  // IDLE
    end
    req_a = 1'b0; req_b = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    req_a = 1'b1; we_a = 1'b0; addr_a = 5'h05;
    step(); step();  // ACCESS, WAIT
    rst = 1'b0; req_a = 1'b0;
    step();
    exp_ra = '0; exp_rb = '0;
    checks++;
    if ({busy, ack_a, ack_b, mem_rd, mem_wr} !== 5'b0 || mem_addr !== '0 ||
        mem_wdata !== '0 || rdata_a !== '0 || rdata_b !== '0) begin
      errors++;
      $display("FAIL mid_reset: busy=%b ack=%b%b rd=%b wr=%b addr=%h wd=%h ra=%h rb=%h required all 0",
               busy, ack_a, ack_b, mem_rd, mem_wr, mem_addr, mem_wdata, rdata_a, rdata_b);
    end
    rst = 1'b1;
    step();
    req_a = 1'b1; addr_a = 5'h06;
    expect_read(1'b0, 5'h06);
    step(); step(); step();
    checks++;
    if (ack_a !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_ack: ack_a=%b required 1", ack_a);
    end
    req_a = 1'b0;
    step();
  endtask

  task automatic test_addr_hold();
    req_a = 1'b1; we_a = 1'b0; addr_a = 5'h02;
    expect_read(1'b0, 5'h02);
    step();  // ACCESS
    addr_a = 5'h07;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (mem_addr !== 5'h02) begin
        errors++;
        $display("FAIL addr_hold[%0d]: mem_addr=%h required 02", c, mem_addr);
      end
      if (c < 2) step();
    end
    checks++;
    if (ack_a !== 1'b1) begin
      errors++;
      $display("FAIL addr_hold_ack: ack_a=%b required 1", ack_a);
    end
    req_a = 1'b0;
    step();
  endtask

  initial begin
    rst = 1'b0; req_a = 1'b0; req_b = 1'b0; we_a = 1'b0; we_b = 1'b0;
    addr_a = '0; addr_b = '0; wdata_a = '0; wdata_b = '0;
    mem_rdata = '0;
    for (int i = 0; i < 32; i++) begin
      mem[i]     = 8'((i * 37 + 11) & 8'hFF);
      ref_mem[i] = mem[i];
    end
    mem[3] = 8'hA5; ref_mem[3] = 8'hA5;
    exp_ra = '0; exp_rb = '0;

    test_reset();
    test_read_a();
    test_write_b();
    test_back_to_back();
    test_reset_mid();
    test_addr_hold();
    step(); step();

    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d completions outstanding, required 0", sbq.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter AWIDTH, default 5, memory address width.
REQ-002 SHALL have parameter DWIDTH, default 8, memory data width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-low reset.
REQ-005 SHALL have ports req_a / req_b  input  1  access request, core port (A) / loader port (B).
REQ-006 SHALL have ports we_a / we_b  input  1  1 = write, 0 = read, qualified by req.
REQ-007 SHALL have ports addr_a / addr_b  input  AWIDTH  request address.
REQ-008 SHALL have ports wdata_a / wdata_b  input  DWIDTH  write data.
REQ-009 SHALL have ports ack_a / ack_b  output  1  one-cycle completion pulse.
REQ-010 SHALL have ports rdata_a / rdata_b  output  DWIDTH  registered read data, valid while ack is high.
REQ-011 SHALL have port mem_addr  output  AWIDTH  memory address.
REQ-012 SHALL have ports mem_rd / mem_wr  output  1  one-cycle memory strobes.
REQ-013 SHALL have port mem_wdata  output  DWIDTH  memory write data.
REQ-014 SHALL have port mem_rdata  input  DWIDTH  memory read data, valid the cycle after mem_rd.
REQ-015 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-016 SHALL implement the FSM states IDLE, ACCESS, WAIT and DONE, with the transitions IDLE->ACCESS (req_a|req_b), ACCESS->WAIT, WAIT->DONE, DONE->IDLE; all other transitions are unconditional.
REQ-017 SHALL, in IDLE with a request, select the winner and latch the winner's addr, we and wdata into internal registers and a grant register.
REQ-018 SHALL, in ACCESS, drive mem_addr from the latched address and assert exactly one of mem_rd / mem_wr (per latched we) for exactly one cycle; mem_wdata = latched wdata on a write, 0 otherwise.
REQ-019 SHALL hold mem_addr at the latched address through WAIT and DONE; mem_rd, mem_wr and mem_wdata SHALL be 0 outside ACCESS.
REQ-020 SHALL, on a read, capture mem_rdata into the granted port's rdata register at the end of WAIT; the other port's rdata SHALL be unchanged.
REQ-021 SHALL leave both rdata registers unchanged on a write.
REQ-022 SHALL pulse the granted port's ack for exactly the DONE cycle; ack_a and ack_b are never high together.
REQ-023 Latency: a req sampled at IDLE edge k SHALL produce ack high in cycle k+3; throughput is one transaction per 4 cycles.
REQ-024 Requesters SHALL hold req, we, addr and wdata until ack; the arbiter ignores all requests outside IDLE, and input changes after latching do not affect the transaction.
REQ-025 The losing requester SHALL remain pending and SHALL be served at the next IDLE in which it is still requesting.

Reset
REQ-026 SHALL, at the first rising clk edge with rst=0, force: state IDLE; ack_a, ack_b, mem_rd, mem_wr and busy = 0; mem_addr, mem_wdata, rdata_a and rdata_b = 0; last-grant = B.
REQ-027 Reset asserted mid-transaction SHALL abort the transaction without ack; any strobe already issued is not retracted, and no further strobe follows.
REQ-028 Asserting rst for consecutive cycles SHALL hold all reset values; the first edge with rst=1 SHALL evaluate IDLE normally.

Configuration
REQ-029 With macro MEM_ARBITER_RR_EN defined, a simultaneous request SHALL be granted to the port not granted last; last-grant updates on every grant.
REQ-030 Without MEM_ARBITER_RR_EN, port A SHALL always win a simultaneous request (fixed priority), and the last-grant register is not implemented.

Verification
REQ-031 Reset, then single read on A (addr=5'h03, mem holds 8'hA5) -> mem_rd high 1 cycle with mem_addr=3; ack_a in cycle k+3 with rdata_a=8'hA5; ack_b stays 0.
REQ-032 Write on B (addr=5'h1F, wdata=8'h3C) -> mem_wr 1 cycle, mem_addr=5'h1F, mem_wdata=8'h3C; ack_b pulses; rdata_a/rdata_b unchanged.
REQ-033 req_a and req_b held together for 4 transactions, RR_EN defined -> grant order A,B,A,B; undefined -> A,A,A,A with B never acked.
REQ-034 rst=0 during WAIT of a read -> no ack, busy=0, all outputs 0 next cycle; a fresh request after release completes normally.
REQ-035 addr_a changed from 5'h02 to 5'h07 during ACCESS -> mem_addr stays 5'h02 through DONE.
